// File: rtl/hb_load_store_unit.sv
// hb_load_store_unit: core-side load/store master for the high-speed bus.
// Takes one RISC-V load/store at a time and screens it for an illegal funct3
// or a misaligned address. Legal requests become one hb read or write pulse.
// The unit then waits, with a timeout, for the slave's finish handshake.
// Load data is sign- or zero-extended and one response strobe is returned
// per accepted request.

module hb_load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        hb_clk,
   input  logic        rst_n,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,

   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        resp_err,

   output logic [31:0] hb_raddr,
   output logic [31:0] hb_waddr,
   output logic [31:0] hb_wdata,
   output logic [1:0]  hb_write_width,
   output logic        hb_ren,
   output logic        hb_wen,
   input  logic [31:0] hb_rdata,
   input  logic        hb_read_finish,
   input  logic        hb_write_finish
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] timeout_cnt_q;
   logic [2:0]       funct3_q;

   logic             accept;
   logic             req_illegal;
   logic             req_misaligned;
   logic             bus_busy;
   logic             read_done;
   logic             write_done;
   logic             access_done;
   logic             timed_out;
   logic [31:0]      load_data;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   // Screen the incoming request: loads allow funct3 0,1,2,4,5 and stores
   // allow 0..2. An illegal funct3 takes priority over misalignment, so the
   // two response flags can never be raised together.
   always_comb begin
      req_illegal    = 1'b0;
      req_misaligned = 1'b0;
      if (req_we) begin
         req_illegal = (req_funct3 > 3'd2);
      end else begin
         req_illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
      end
      if (!req_illegal) begin
         case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
         endcase
      end
   end

   // Finish qualification: a read finish in the pulse cycle (hb_ren still
   // high) is too early to be real, while a write may complete in the
   // same cycle as its pulse.
   assign bus_busy    = (state_q == READ) || (state_q == WRITE);
   assign read_done   = (state_q == READ) && !hb_ren && hb_read_finish;
   assign write_done  = (state_q == WRITE) && hb_write_finish;
   assign access_done = read_done || write_done;
   assign timed_out   = bus_busy && !access_done && (timeout_cnt_q == CNT_LAST);

   // Extend the slave's right-justified load data according to funct3.
   always_comb begin
      load_data = hb_rdata;
      case (funct3_q)
         3'd0:    load_data = {{24{hb_rdata[7]}}, hb_rdata[7:0]};
         3'd1:    load_data = {{16{hb_rdata[15]}}, hb_rdata[15:0]};
         3'd4:    load_data = {24'd0, hb_rdata[7:0]};
         3'd5:    load_data = {16'd0, hb_rdata[15:0]};
         default: load_data = hb_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: faulty requests go straight to RESP, legal ones
   // visit READ or WRITE until a finish or the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_illegal || req_misaligned) begin
                  state_d = RESP;
               end else if (req_we) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ, WRITE: begin
            if (access_done || timed_out) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Timeout counter: cleared while idle, counts every busy cycle that
   // brings no finish; reaching the last count forces the error response.
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_cnt_q <= '0;
      end else if (state_q == IDLE) begin
         timeout_cnt_q <= '0;
      end else if (bus_busy && !access_done) begin
         timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
      end
   end

   // Remember funct3 of the accepted request for the load extension.
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_q <= 3'd0;
      end else if (accept) begin
         funct3_q <= req_funct3;
      end
   end

   // Bus request registers: the address, data and width are loaded on the
   // way into READ/WRITE and held until the next access; the enables are
   // single-cycle pulses.
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_raddr       <= 32'd0;
         hb_waddr       <= 32'd0;
         hb_wdata       <= 32'd0;
         hb_write_width <= 2'b00;
         hb_ren         <= 1'b0;
         hb_wen         <= 1'b0;
      end else begin
         hb_ren <= 1'b0;
         hb_wen <= 1'b0;
         if (accept && !req_illegal && !req_misaligned) begin
            hb_raddr       <= req_addr;
            hb_waddr       <= req_addr;
            hb_wdata       <= req_wdata;
            hb_write_width <= req_funct3[1:0];
            hb_ren         <= !req_we;
            hb_wen         <= req_we;
         end
      end
   end

   // Response registers: loaded on the edge that enters RESP so the strobe
   // and its flags appear together for exactly the one RESP cycle.
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid      <= 1'b0;
         resp_rdata      <= 32'd0;
         resp_misaligned <= 1'b0;
         resp_err        <= 1'b0;
      end else begin
         resp_valid      <= 1'b0;
         resp_rdata      <= 32'd0;
         resp_misaligned <= 1'b0;
         resp_err        <= 1'b0;
         if (state_d == RESP && state_q != RESP) begin
            resp_valid <= 1'b1;
            if (state_q == IDLE) begin
               resp_err        <= req_illegal;
               resp_misaligned <= req_misaligned;
            end else if (timed_out) begin
               resp_err <= 1'b1;
            end else if (read_done) begin
               resp_rdata <= load_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_hb_load_store_unit.sv
// tb_hb_load_store_unit: randomized bench for hb_load_store_unit with a
// transaction-level reference model and a small scripted hb slave.

module tb_hb_load_store_unit;

   localparam int T = 4;

   logic        hb_clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic        resp_err;
   logic [31:0] hb_raddr;
   logic [31:0] hb_waddr;
   logic [31:0] hb_wdata;
   logic [1:0]  hb_write_width;
   logic        hb_ren;
   logic        hb_wen;
   logic [31:0] hb_rdata;
   logic        hb_read_finish;
   logic        hb_write_finish;

   int checks   = 0;
   int failures = 0;

   hb_load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .hb_clk          (hb_clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_misaligned (resp_misaligned),
      .resp_err        (resp_err),
      .hb_raddr        (hb_raddr),
      .hb_waddr        (hb_waddr),
      .hb_wdata        (hb_wdata),
      .hb_write_width  (hb_write_width),
      .hb_ren          (hb_ren),
      .hb_wen          (hb_wen),
      .hb_rdata        (hb_rdata),
      .hb_read_finish  (hb_read_finish),
      .hb_write_finish (hb_write_finish)
   );

   // Free-running clock.
   initial hb_clk = 1'b0;
   always #5 hb_clk = ~hb_clk;

   // Absolute bound on the run in case a wait is ever missed.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=expired expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference extension of load data, from plain arithmetic on funct3.
   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] d);
      int v;
      case (f3)
         3'd0:    v = int'(d[7:0]) - (d[7] ? 256 : 0);
         3'd1:    v = int'(d[15:0]) - (d[15] ? 65536 : 0);
         3'd4:    v = int'(d[7:0]);
         3'd5:    v = int'(d[15:0]);
         default: v = int'(d);
      endcase
      return 32'(v);
   endfunction

   // One transaction, entered and left at a falling edge. The finish for
   // the access is raised in cycle 1+delay, where cycle 0 is the accepting
   // edge and the bus pulse is expected in cycle 1.
   task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] slave_data, input int delay);
      logic        legal;
      logic        aligned;
      logic        access;
      logic        ok;
      int          finish_cycle;
      int          exp_cycle;
      logic [31:0] exp_rdata;
      logic [31:0] ren_mask;
      logic [31:0] wen_mask;
      logic        held_ok;
      int          got_cycle;
      logic [31:0] got_rdata;
      logic        got_err;
      logic        got_mis;

      legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      aligned = (f3[1:0] == 2'd0) || (f3[1:0] == 2'd1 && addr[0] == 1'b0) ||
                (f3[1:0] == 2'd2 && addr[1:0] == 2'd0);
      access  = legal && aligned;
      finish_cycle = 1 + delay;
      ok = (finish_cycle >= (we ? 1 : 2)) && (finish_cycle <= T);
      if (!access)  exp_cycle = 1;
      else if (ok)  exp_cycle = finish_cycle + 1;
      else          exp_cycle = T + 1;
      exp_rdata = (access && ok && !we) ? modelLoad(f3, slave_data) : 32'd0;

      checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid       = 1'b1;
      req_we          = we;
      req_funct3      = f3;
      req_addr        = addr;
      req_wdata       = wdata;
      hb_rdata        = slave_data;
      hb_read_finish  = 1'($urandom_range(0, 1));
      hb_write_finish = 1'($urandom_range(0, 1));
      @(posedge hb_clk);
      @(negedge hb_clk);

      ren_mask  = 32'd0;
      wen_mask  = 32'd0;
      held_ok   = 1'b1;
      got_cycle = 0;
      got_rdata = 32'd0;
      got_err   = 1'b0;
      got_mis   = 1'b0;
      for (int c = 1; c <= 12 && got_cycle == 0; c++) begin
         if (hb_ren) ren_mask[c] = 1'b1;
         if (hb_wen) wen_mask[c] = 1'b1;
         checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
         if (resp_valid) begin
            got_cycle = c;
            got_rdata = resp_rdata;
            got_err   = resp_err;
            got_mis   = resp_misaligned;
         end else if (access) begin
            if (hb_raddr !== addr || hb_waddr !== addr || hb_write_width !== f3[1:0]) held_ok = 1'b0;
            if (we && hb_wdata !== wdata) held_ok = 1'b0;
         end
         hb_read_finish  = !we && (c == finish_cycle);
         hb_write_finish = we && (c == finish_cycle);
         hb_rdata        = slave_data;
         req_valid       = 1'b1;
         req_we          = 1'($urandom_range(0, 1));
         req_funct3      = 3'($urandom_range(0, 7));
         req_addr        = $urandom;
         @(posedge hb_clk);
         @(negedge hb_clk);
      end
      hb_read_finish  = 1'b0;
      hb_write_finish = 1'b0;

      checkOutput("resp_cycle", 32'(got_cycle), 32'(exp_cycle));
      checkOutput("resp_rdata", got_rdata, exp_rdata);
      checkOutput("resp_err", {31'd0, got_err}, {31'd0, !legal || (access && !ok)});
      checkOutput("resp_misaligned", {31'd0, got_mis}, {31'd0, legal && !aligned});
      checkOutput("ren_pulse_cycles", ren_mask, (access && !we) ? 32'h2 : 32'h0);
      checkOutput("wen_pulse_cycles", wen_mask, (access && we) ? 32'h2 : 32'h0);
      if (access) checkOutput("bus_fields_held", {31'd0, held_ok}, 32'd1);
   endtask

   // Pull reset low in the pulse cycle of an access and confirm it is dropped.
   task automatic resetDuringAccess(input logic we);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = 3'd2;
      req_addr   = 32'h0000_0200;
      req_wdata  = 32'hCAFE_F00D;
      @(posedge hb_clk);
      @(negedge hb_clk);
      req_valid = 1'b0;
      checkOutput("rst_pre_pulse", {30'd0, hb_wen, hb_ren}, we ? 32'h2 : 32'h1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_enables", {30'd0, hb_wen, hb_ren}, 32'h0);
      checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge hb_clk);
      rst_n = 1'b1;
      hb_read_finish  = 1'b1;
      hb_write_finish = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge hb_clk);
         checkOutput("rst_no_resp", {30'd0, resp_valid, req_ready}, 32'h1);
      end
      hb_read_finish  = 1'b0;
      hb_write_finish = 1'b0;
   endtask

   // Directed cases first, then randomized traffic, then reset cases.
   initial begin
      rst_n           = 1'b0;
      req_valid       = 1'b0;
      req_we          = 1'b0;
      req_funct3      = 3'd0;
      req_addr        = 32'd0;
      req_wdata       = 32'd0;
      hb_rdata        = 32'd0;
      hb_read_finish  = 1'b0;
      hb_write_finish = 1'b0;
      @(negedge hb_clk);
      @(negedge hb_clk);
      checkOutput("reset_resp", {29'd0, resp_valid, resp_err, resp_misaligned}, 32'd0);
      checkOutput("reset_rdata", resp_rdata, 32'd0);
      checkOutput("reset_enables", {30'd0, hb_ren, hb_wen}, 32'd0);
      checkOutput("reset_addr", hb_raddr | hb_waddr | hb_wdata, 32'd0);
      checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge hb_clk);

      $display("[TB] directed cases");
      applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1);
      applyStimulus(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h0000_0080, 1);
      applyStimulus(1'b0, 3'd4, 32'h0000_0103, 32'd0, 32'h0000_0080, 1);
      applyStimulus(1'b0, 3'd1, 32'h0000_0102, 32'd0, 32'h0000_8001, 1);
      applyStimulus(1'b0, 3'd5, 32'h0000_0102, 32'd0, 32'h0000_8001, 1);
      applyStimulus(1'b1, 3'd1, 32'h0000_000A, 32'h0000_1234, 32'd0, 0);
      applyStimulus(1'b0, 3'd2, 32'h0000_0101, 32'd0, 32'h1111_1111, 1);
      applyStimulus(1'b0, 3'd3, 32'h0000_0100, 32'd0, 32'h1111_1111, 1);
      applyStimulus(1'b1, 3'd4, 32'h0000_0100, 32'h5555_5555, 32'd0, 0);
      applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'h2222_2222, 20);
      applyStimulus(1'b1, 3'd2, 32'h0000_0104, 32'h3333_3333, 32'd0, 20);
      applyStimulus(1'b0, 3'd2, 32'h0000_0108, 32'd0, 32'h4444_4444, 0);
      applyStimulus(1'b0, 3'd1, 32'h0000_010C, 32'd0, 32'h1234_F00F, T - 1);
      applyStimulus(1'b1, 3'd0, 32'h0000_0111, 32'h0000_00AB, 32'd0, T - 1);

      $display("[TB] randomized cases");
      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                       $urandom, $urandom, int'($urandom_range(0, 5)));
      end

      $display("[TB] reset during access");
      req_valid = 1'b0;
      @(negedge hb_clk);
      resetDuringAccess(1'b0);
      resetDuringAccess(1'b1);
      applyStimulus(1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'h0BAD_F00D, 2);
      req_valid = 1'b0;
      @(negedge hb_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
